// File: rtl/msi_directory.sv
// MSI coherence directory: fully associative entries with sharer vectors,
// victim replacement with writeback, and a single outstanding request.
module msi_directory #(
  parameter int NUM_PROC = 2,
  parameter int ENTRIES  = 4,
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 4,
  localparam int PW = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1
) (
  input  logic                Clock,
  input  logic                Resetn,
  input  logic                ReqValid,
  output logic                ReqReady,
  input  logic [PW-1:0]       ReqProc,
  input  logic [1:0]          ReqOp,
  input  logic [ADDR_W-1:0]   ReqAddr,
  input  logic [DATA_W-1:0]   ReqData,
  output logic                MemRdReq,
  output logic [ADDR_W-1:0]   MemRdAddr,
  input  logic                MemRdValid,
  input  logic [DATA_W-1:0]   MemRdData,
  output logic                MemWr,
  output logic [ADDR_W-1:0]   MemWrAddr,
  output logic [DATA_W-1:0]   MemWrData,
  output logic [NUM_PROC-1:0] InvVec,
  output logic [NUM_PROC-1:0] FetchVec,
  output logic                RespValid,
  output logic [2:0]          RespState,
  output logic [DATA_W-1:0]   RespData,
  output logic                RespErr
);

  localparam int EW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam logic [1:0] OP_RD = 2'b00;
  localparam logic [1:0] OP_WB = 2'b11;
  localparam logic [2:0] ST_E = 3'b000;
  localparam logic [2:0] ST_I = 3'b001;
  localparam logic [2:0] ST_S = 3'b010;
  localparam logic [2:0] ST_M = 3'b011;

  typedef enum logic [1:0] {IDLE, LOOKUP, MEMRD, RESP} fsm_e;
  fsm_e state_q, state_d;

  logic [PW-1:0]       proc_q;
  logic [1:0]          op_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdat_q;
  logic                e_vld_q  [ENTRIES];
  logic [ADDR_W-1:0]   e_addr_q [ENTRIES];
  logic [2:0]          e_st_q   [ENTRIES];
  logic [DATA_W-1:0]   e_dat_q  [ENTRIES];
  logic [NUM_PROC-1:0] e_shr_q  [ENTRIES];
  logic [EW-1:0]       vptr_q, vic_q;
  logic [2:0]          rsp_st_q;
  logic [DATA_W-1:0]   rsp_dat_q;
  logic                rsp_err_q;

  logic                hit, free;
  logic [EW-1:0]       hidx, fidx, vidx;
  logic [NUM_PROC-1:0] rbit;
  logic                is_wb, is_rd;

  logic                wr_en, wr_vld, vic_ld, vptr_inc;
  logic [EW-1:0]       wr_idx;
  logic [ADDR_W-1:0]   wr_addr;
  logic [2:0]          wr_st;
  logic [DATA_W-1:0]   wr_dat;
  logic [NUM_PROC-1:0] wr_shr;
  logic                rsp_ld, rsp_err;

  // Hit only counts live (S/M) lines; I and empty lines are replaceable
  always_comb begin
    hit  = 1'b0;
    hidx = '0;
    free = 1'b0;
    fidx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (e_st_q[i] == ST_S || e_st_q[i] == ST_M) begin
        if (e_vld_q[i] && e_addr_q[i] == addr_q) begin
          hit  = 1'b1;
          hidx = EW'(i);
        end
      end else begin
        free = 1'b1;
        fidx = EW'(i);
      end
    end
  end

  assign vidx  = free ? fidx : vptr_q;
  assign rbit  = NUM_PROC'(1) << proc_q;
  assign is_wb = (op_q == OP_WB);
  assign is_rd = (op_q == OP_RD);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (ReqValid) state_d = LOOKUP;
      LOOKUP:  state_d = (hit || is_wb) ? RESP : MEMRD;
      MEMRD:   if (MemRdValid) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    InvVec    = '0;
    FetchVec  = '0;
    MemWr     = 1'b0;
    MemWrAddr = '0;
    MemWrData = '0;
    wr_en     = 1'b0;
    wr_idx    = hidx;
    wr_vld    = 1'b1;
    wr_addr   = addr_q;
    wr_st     = e_st_q[hidx];
    wr_dat    = e_dat_q[hidx];
    wr_shr    = e_shr_q[hidx];
    vic_ld    = 1'b0;
    vptr_inc  = 1'b0;
    rsp_ld    = 1'b0;
    rsp_err   = 1'b0;
    if (state_q == LOOKUP) begin
      unique case (1'b1)
        is_wb: begin
          rsp_ld = 1'b1;
          if (hit && |(e_shr_q[hidx] & rbit)) begin
            wr_en  = 1'b1;
            wr_shr = e_shr_q[hidx] & ~rbit;
            wr_st  = |wr_shr ? ST_S : ST_I;
            if (e_st_q[hidx] == ST_M) wr_dat = wdat_q;
          end else begin
            rsp_err = 1'b1;
            if (!hit) begin
              wr_st  = ST_E;
              wr_dat = '0;
            end
          end
        end
        !is_wb && hit && is_rd: begin
          wr_en  = 1'b1;
          rsp_ld = 1'b1;
          if (e_st_q[hidx] == ST_M && e_shr_q[hidx] != rbit) begin
            FetchVec = e_shr_q[hidx];
            wr_st    = ST_S;
          end
          wr_shr = e_shr_q[hidx] | rbit;
        end
        !is_wb && hit && !is_rd: begin
          wr_en  = 1'b1;
          rsp_ld = 1'b1;
          InvVec = e_shr_q[hidx] & ~rbit;
          wr_st  = ST_M;
          wr_shr = rbit;
          wr_dat = wdat_q;
        end
        default: begin
          vic_ld = 1'b1;
          if (!free) begin
            InvVec    = e_shr_q[vptr_q];
            MemWr     = (e_st_q[vptr_q] == ST_M);
            MemWrAddr = MemWr ? e_addr_q[vptr_q] : '0;
            MemWrData = MemWr ? e_dat_q[vptr_q] : '0;
            wr_en     = 1'b1;
            wr_idx    = vptr_q;
            wr_addr   = e_addr_q[vptr_q];
            wr_st     = ST_I;
            wr_dat    = e_dat_q[vptr_q];
            wr_shr    = '0;
            vptr_inc  = 1'b1;
          end
        end
      endcase
    end else if (state_q == MEMRD && MemRdValid) begin
      wr_en  = 1'b1;
      rsp_ld = 1'b1;
      wr_idx = vic_q;
      wr_st  = is_rd ? ST_S : ST_M;
      wr_dat = is_rd ? MemRdData : wdat_q;
      wr_shr = rbit;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      proc_q    <= '0;
      op_q      <= '0;
      addr_q    <= '0;
      wdat_q    <= '0;
      vptr_q    <= '0;
      vic_q     <= '0;
      rsp_st_q  <= '0;
      rsp_dat_q <= '0;
      rsp_err_q <= 1'b0;
      for (int i = 0; i < ENTRIES; i++) begin
        e_vld_q[i]  <= 1'b0;
        e_addr_q[i] <= '0;
        e_st_q[i]   <= ST_E;
        e_dat_q[i]  <= '0;
        e_shr_q[i]  <= '0;
      end
    end else begin
      if (state_q == IDLE && ReqValid) begin
        proc_q <= ReqProc;
        op_q   <= ReqOp;
        addr_q <= ReqAddr;
        wdat_q <= ReqData;
      end
      if (vic_ld) vic_q <= vidx;
      if (vptr_inc)
        vptr_q <= (vptr_q == EW'(ENTRIES - 1)) ? '0 : vptr_q + EW'(1);
      if (wr_en) begin
        e_vld_q[wr_idx]  <= wr_vld;
        e_addr_q[wr_idx] <= wr_addr;
        e_st_q[wr_idx]   <= wr_st;
        e_dat_q[wr_idx]  <= wr_dat;
        e_shr_q[wr_idx]  <= wr_shr;
      end
      if (rsp_ld) begin
        rsp_st_q  <= wr_st;
        rsp_dat_q <= wr_dat;
        rsp_err_q <= rsp_err;
      end
    end
  end

  assign ReqReady  = (state_q == IDLE) && Resetn;
  assign MemRdReq  = (state_q == MEMRD);
  assign MemRdAddr = MemRdReq ? addr_q : '0;
  assign RespValid = (state_q == RESP);
  assign RespState = rsp_st_q;
  assign RespData  = rsp_dat_q;
  assign RespErr   = RespValid && rsp_err_q;

endmodule

// File: tb/tb_msi_directory.sv
// Directed bench for msi_directory: fills, sharing, upgrades, fetches,
// writebacks, victim replacement and mid-operation reset.
module tb_msi_directory;
  localparam logic [1:0] RD = 2'b00, WR = 2'b01, UP = 2'b10, WB = 2'b11;

  logic       Clock = 1'b0;
  logic       Resetn;
  logic       ReqValid, ReqReady;
  logic [0:0] ReqProc;
  logic [1:0] ReqOp;
  logic [3:0] ReqAddr, ReqData;
  logic       MemRdReq;
  logic [3:0] MemRdAddr;
  logic       MemRdValid;
  logic [3:0] MemRdData;
  logic       MemWr;
  logic [3:0] MemWrAddr, MemWrData;
  logic [1:0] InvVec, FetchVec;
  logic       RespValid;
  logic [2:0] RespState;
  logic [3:0] RespData;
  logic       RespErr;

  int pass = 0;
  int total = 0;

  logic [1:0] l_inv, l_fetch;
  logic       l_mw;
  logic [3:0] l_mwa, l_mwd;
  int         cyc;
  logic       rd_seen, pulse_after;
  logic [3:0] rd_addr;
  logic       r_v, r_e, r_v2;
  logic [2:0] r_st, r_st2;
  logic [3:0] r_d;

  msi_directory #(
    .NUM_PROC(2), .ENTRIES(4), .ADDR_W(4), .DATA_W(4)
  ) dut (
    .Clock(Clock), .Resetn(Resetn),
    .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ReqProc(ReqProc), .ReqOp(ReqOp),
    .ReqAddr(ReqAddr), .ReqData(ReqData),
    .MemRdReq(MemRdReq), .MemRdAddr(MemRdAddr),
    .MemRdValid(MemRdValid), .MemRdData(MemRdData),
    .MemWr(MemWr), .MemWrAddr(MemWrAddr), .MemWrData(MemWrData),
    .InvVec(InvVec), .FetchVec(FetchVec),
    .RespValid(RespValid), .RespState(RespState),
    .RespData(RespData), .RespErr(RespErr)
  );

  always #5 Clock = ~Clock;

  task automatic issue(input logic [0:0] p, input logic [1:0] op,
                       input logic [3:0] a, input logic [3:0] d);
    @(negedge Clock);
    ReqValid = 1'b1; ReqProc = p; ReqOp = op;
    ReqAddr = a; ReqData = d;
    @(posedge Clock); #1;
    ReqValid = 1'b0;
    l_inv = InvVec; l_fetch = FetchVec;
    l_mw = MemWr; l_mwa = MemWrAddr; l_mwd = MemWrData;
  endtask

  task automatic wait_resp(input logic [3:0] md, input int dly,
                           input logic junk);
    int cnt;
    cnt = 0; cyc = 0; rd_seen = 1'b0; rd_addr = '0; pulse_after = 1'b0;
    while (cyc < 20 && !RespValid) begin
      if (cyc > 0 && (InvVec != 0 || FetchVec != 0 || MemWr))
        pulse_after = 1'b1;
      if (MemRdReq) begin
        rd_seen = 1'b1; rd_addr = MemRdAddr; cnt++;
        if (cnt > dly) begin MemRdValid = 1'b1; MemRdData = md; end
      end else if (junk) begin
        MemRdValid = 1'b1; MemRdData = ~md;
      end
      @(posedge Clock); #1;
      MemRdValid = 1'b0;
      cyc++;
    end
    r_v = RespValid; r_st = RespState; r_d = RespData; r_e = RespErr;
    if (InvVec != 0 || FetchVec != 0 || MemWr) pulse_after = 1'b1;
    @(posedge Clock); #1;
    r_v2 = RespValid; r_st2 = RespState;
  endtask

  task automatic test_reset;
    Resetn = 1'b0; ReqValid = 1'b0; ReqProc = '0; ReqOp = '0;
    ReqAddr = '0; ReqData = '0; MemRdValid = 1'b0; MemRdData = '0;
    repeat (2) @(posedge Clock);
    #1;
    total++; if (ReqReady !== 1'b0) $display("FAIL rst_ready: got %b want 0", ReqReady); else pass++;
    total++; if ({RespValid, MemRdReq, MemWr, InvVec, FetchVec} !== 7'b0) $display("FAIL rst_pulses: got %b want 0", {RespValid, MemRdReq, MemWr, InvVec, FetchVec}); else pass++;
    total++; if ({RespState, RespData, RespErr} !== 8'b0) $display("FAIL rst_resp: got %h want 0", {RespState, RespData, RespErr}); else pass++;
    @(negedge Clock); Resetn = 1'b1; #1;
    total++; if (ReqReady !== 1'b1) $display("FAIL rst_release_ready: got %b want 1", ReqReady); else pass++;
  endtask

  task automatic test_read_miss;
    issue(1'b0, RD, 4'h1, 4'h0);
    total++; if ({l_inv, l_mw} !== 3'b0) $display("FAIL rm_lookup: got %b want 000", {l_inv, l_mw}); else pass++;
    wait_resp(4'h2, 0, 1'b0);
    total++; if (!rd_seen || rd_addr !== 4'h1) $display("FAIL rm_rdaddr: got %b/%h want 1/1", rd_seen, rd_addr); else pass++;
    total++; if (cyc !== 2 || r_v !== 1'b1) $display("FAIL rm_latency: got %0d want 2", cyc); else pass++;
    total++; if ({r_st, r_d, r_e} !== {3'b010, 4'h2, 1'b0}) $display("FAIL rm_resp: got %b/%h/%b want 010/2/0", r_st, r_d, r_e); else pass++;
    total++; if (r_v2 !== 1'b0 || r_st2 !== 3'b010) $display("FAIL rm_hold: got %b/%b want 0/010", r_v2, r_st2); else pass++;
  endtask

  task automatic test_read_share;
    issue(1'b1, RD, 4'h1, 4'h0);
    wait_resp(4'h0, 0, 1'b1);
    total++; if (rd_seen !== 1'b0) $display("FAIL rs_nomem: got %b want 0", rd_seen); else pass++;
    total++; if (cyc !== 1) $display("FAIL rs_latency: got %0d want 1", cyc); else pass++;
    total++; if ({r_st, r_d} !== {3'b010, 4'h2}) $display("FAIL rs_resp: got %b/%h want 010/2", r_st, r_d); else pass++;
  endtask

  task automatic test_upgrade;
    issue(1'b1, UP, 4'h1, 4'h9);
    total++; if ({l_inv, l_fetch} !== 4'b0100) $display("FAIL up_inv: got %b/%b want 01/00", l_inv, l_fetch); else pass++;
    wait_resp(4'h0, 0, 1'b0);
    total++; if (pulse_after !== 1'b0) $display("FAIL up_pulse_len: got %b want 0", pulse_after); else pass++;
    total++; if ({r_st, r_d} !== {3'b011, 4'h9} || cyc !== 1) $display("FAIL up_resp: got %b/%h/%0d want 011/9/1", r_st, r_d, cyc); else pass++;
  endtask

  task automatic test_fetch;
    issue(1'b0, RD, 4'h1, 4'h0);
    total++; if ({l_fetch, l_inv} !== 4'b1000) $display("FAIL fe_fetch: got %b/%b want 10/00", l_fetch, l_inv); else pass++;
    wait_resp(4'h0, 0, 1'b0);
    total++; if ({r_st, r_d} !== {3'b010, 4'h9} || rd_seen) $display("FAIL fe_resp: got %b/%h/%b want 010/9/0", r_st, r_d, rd_seen); else pass++;
  endtask

  task automatic test_writeback;
    issue(1'b0, WB, 4'h1, 4'h5);
    wait_resp(4'h0, 0, 1'b0);
    total++; if ({r_st, r_d, r_e} !== {3'b010, 4'h9, 1'b0}) $display("FAIL wb_s: got %b/%h/%b want 010/9/0", r_st, r_d, r_e); else pass++;
    issue(1'b0, WB, 4'h1, 4'h5);
    wait_resp(4'h0, 0, 1'b0);
    total++; if (r_e !== 1'b1 || r_v !== 1'b1) $display("FAIL wb_nonsharer_err: got %b want 1", r_e); else pass++;
    issue(1'b0, WB, 4'h7, 4'h5);
    wait_resp(4'h0, 0, 1'b0);
    total++; if (r_e !== 1'b1 || rd_seen) $display("FAIL wb_miss_err: got %b want 1", r_e); else pass++;
    issue(1'b1, WR, 4'h1, 4'hC);
    total++; if (l_inv !== 2'b00) $display("FAIL wr_hit_inv: got %b want 00", l_inv); else pass++;
    wait_resp(4'h0, 0, 1'b0);
    total++; if ({r_st, r_d, r_e} !== {3'b011, 4'hC, 1'b0}) $display("FAIL wr_hit_resp: got %b/%h/%b want 011/c/0", r_st, r_d, r_e); else pass++;
    issue(1'b1, WB, 4'h1, 4'hD);
    wait_resp(4'h0, 0, 1'b0);
    total++; if ({r_st, r_d, r_e} !== {3'b001, 4'hD, 1'b0}) $display("FAIL wb_m_last: got %b/%h/%b want 001/d/0", r_st, r_d, r_e); else pass++;
    issue(1'b0, RD, 4'h1, 4'h0);
    total++; if ({l_inv, l_mw} !== 3'b0) $display("FAIL rd_after_i_lookup: got %b want 000", {l_inv, l_mw}); else pass++;
    wait_resp(4'h3, 0, 1'b0);
    total++; if (!rd_seen || {r_st, r_d} !== {3'b010, 4'h3}) $display("FAIL rd_after_i: got %b/%b/%h want 1/010/3", rd_seen, r_st, r_d); else pass++;
  endtask

  task automatic test_victim;
    issue(1'b0, RD, 4'h2, 4'h0);
    wait_resp(4'h4, 0, 1'b0);
    total++; if ({r_st, r_d} !== {3'b010, 4'h4}) $display("FAIL fill2: got %b/%h want 010/4", r_st, r_d); else pass++;
    issue(1'b1, WR, 4'h3, 4'h6);
    wait_resp(4'h5, 2, 1'b1);
    total++; if (cyc !== 4 || rd_addr !== 4'h3) $display("FAIL fill3_delay: got %0d/%h want 4/3", cyc, rd_addr); else pass++;
    total++; if ({r_st, r_d} !== {3'b011, 4'h6}) $display("FAIL fill3_resp: got %b/%h want 011/6", r_st, r_d); else pass++;
    issue(1'b1, RD, 4'h3, 4'h0);
    total++; if (l_fetch !== 2'b00) $display("FAIL own_rd_fetch: got %b want 00", l_fetch); else pass++;
    wait_resp(4'h0, 0, 1'b0);
    total++; if ({r_st, r_d} !== {3'b011, 4'h6} || cyc !== 1) $display("FAIL own_rd_resp: got %b/%h/%0d want 011/6/1", r_st, r_d, cyc); else pass++;
    issue(1'b0, RD, 4'h4, 4'h0);
    wait_resp(4'h8, 0, 1'b0);
    total++; if ({r_st, r_d} !== {3'b010, 4'h8}) $display("FAIL fill4: got %b/%h want 010/8", r_st, r_d); else pass++;
    issue(1'b1, WR, 4'h1, 4'hA);
    total++; if (l_inv !== 2'b01) $display("FAIL wr_e0_inv: got %b want 01", l_inv); else pass++;
    wait_resp(4'h0, 0, 1'b0);
    issue(1'b0, RD, 4'h5, 4'h0);
    total++; if (l_inv !== 2'b10) $display("FAIL vic0_inv: got %b want 10", l_inv); else pass++;
    total++; if ({l_mw, l_mwa, l_mwd} !== {1'b1, 4'h1, 4'hA}) $display("FAIL vic0_memwr: got %b/%h/%h want 1/1/a", l_mw, l_mwa, l_mwd); else pass++;
    wait_resp(4'hB, 0, 1'b0);
    total++; if (pulse_after !== 1'b0 || {r_st, r_d} !== {3'b010, 4'hB}) $display("FAIL vic0_resp: got %b/%b/%h want 0/010/b", pulse_after, r_st, r_d); else pass++;
    issue(1'b1, RD, 4'h6, 4'h0);
    total++; if ({l_inv, l_mw} !== 3'b010) $display("FAIL vic1: got %b/%b want 01/0", l_inv, l_mw); else pass++;
    wait_resp(4'hE, 0, 1'b0);
    issue(1'b0, RD, 4'h1, 4'h0);
    total++; if ({l_inv, l_mw, l_mwa, l_mwd} !== {2'b10, 1'b1, 4'h3, 4'h6}) $display("FAIL vic2: got %b/%b/%h/%h want 10/1/3/6", l_inv, l_mw, l_mwa, l_mwd); else pass++;
    wait_resp(4'h7, 0, 1'b0);
    total++; if (!rd_seen || {r_st, r_d} !== {3'b010, 4'h7}) $display("FAIL vic2_resp: got %b/%b/%h want 1/010/7", rd_seen, r_st, r_d); else pass++;
  endtask

  task automatic test_reset_mid;
    logic seen;
    issue(1'b0, RD, 4'h9, 4'h0);
    total++; if ({l_inv, l_mw} !== 3'b010) $display("FAIL vic3: got %b/%b want 01/0", l_inv, l_mw); else pass++;
    @(posedge Clock); #1;
    total++; if (MemRdReq !== 1'b1) $display("FAIL mid_memrd: got %b want 1", MemRdReq); else pass++;
    Resetn = 1'b0; #1;
    total++; if ({MemRdReq, ReqReady, RespValid} !== 3'b0) $display("FAIL mid_rst_out: got %b want 000", {MemRdReq, ReqReady, RespValid}); else pass++;
    seen = 1'b0;
    repeat (3) begin
      MemRdValid = 1'b1; MemRdData = 4'hF;
      @(posedge Clock); #1;
      if (RespValid || MemWr) seen = 1'b1;
    end
    MemRdValid = 1'b0;
    @(negedge Clock); Resetn = 1'b1; #1;
    total++; if (ReqReady !== 1'b1) $display("FAIL mid_ready: got %b want 1", ReqReady); else pass++;
    @(posedge Clock); #1;
    if (RespValid || MemWr) seen = 1'b1;
    total++; if (seen !== 1'b0) $display("FAIL mid_noresp: got %b want 0", seen); else pass++;
    issue(1'b0, RD, 4'h1, 4'h0);
    total++; if ({l_inv, l_mw} !== 3'b0) $display("FAIL post_rst_lookup: got %b want 000", {l_inv, l_mw}); else pass++;
    wait_resp(4'h6, 0, 1'b0);
    total++; if (!rd_seen || {r_st, r_d} !== {3'b010, 4'h6}) $display("FAIL post_rst_miss: got %b/%b/%h want 1/010/6", rd_seen, r_st, r_d); else pass++;
  endtask

  initial begin
    test_reset;
    test_read_miss;
    test_read_share;
    test_upgrade;
    test_fetch;
    test_writeback;
    test_victim;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
